// File: rtl/mac_dot_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mac_dot_pipe
// Purpose  : Two-stage pipelined signed multiply-accumulate computing a
//            LEN-element dot product of w/x pairs, with optional saturation
//            and a sticky overflow flag per result.
// Ports    : clk, rst (async, active-high), clr (sync abort)
//            in_valid/in_ready/w/x     - operand pair handshake
//            out_valid/out_ready/out/ovf - result handshake
// Revision : 1.0 - initial release
// ============================================================================
module mac_dot_pipe #(
    parameter  int WIDTH     = 8,
    parameter  int LEN       = 4,
    parameter  int GUARD     = 4,
    parameter  int SAT       = 1,
    localparam int ACC_WIDTH = 2 * WIDTH + GUARD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     w,
    input  logic [WIDTH-1:0]     x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out,
    output logic                 ovf
);

    localparam int                   c_PROD_W   = 2 * WIDTH;
    localparam int                   c_CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(LEN - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [ACC_WIDTH-1:0] c_ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic                 w_stall;
    logic                 w_accept;
    logic                 w_add;
    logic                 w_last;
    logic                 w_load;
    logic [c_PROD_W-1:0]  w_mul;
    logic [ACC_WIDTH:0]   w_sum_ext;
    logic                 w_add_ovf;
    logic [ACC_WIDTH-1:0] w_sum;

    logic [c_PROD_W-1:0]  r_prod;
    logic                 r_prod_vld;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_sticky;

    // A held, unconsumed result freezes the whole pipeline.
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall & ~rst;
    // clr aborts the vector, so a pair offered in the same cycle is refused.
    assign w_accept = in_valid & in_ready & ~clr;

    // Sign-extend both operands to the product width; the low 2*WIDTH bits of
    // the product are then the exact signed result.
    assign w_mul = {{WIDTH{w[WIDTH-1]}}, w} * {{WIDTH{x[WIDTH-1]}}, x};

    // One extra bit above the accumulator exposes signed overflow: the top
    // two bits of the widened sum disagree exactly when the true sum is out
    // of the ACC_WIDTH signed range.
    assign w_sum_ext = {r_acc[ACC_WIDTH-1], r_acc}
                     + {{(GUARD+1){r_prod[c_PROD_W-1]}}, r_prod};
    assign w_add_ovf = w_sum_ext[ACC_WIDTH] ^ w_sum_ext[ACC_WIDTH-1];

    generate
        if (SAT != 0) begin : g_sat
            // Bit ACC_WIDTH carries the true sign of the sum.
            assign w_sum = w_add_ovf ? (w_sum_ext[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX)
                                     : w_sum_ext[ACC_WIDTH-1:0];
        end else begin : g_wrap
            assign w_sum = w_sum_ext[ACC_WIDTH-1:0];
        end
    endgenerate

    assign w_add  = r_prod_vld & ~w_stall;
    assign w_last = (r_cnt == c_CNT_LAST);
    assign w_load = w_add & w_last & ~clr;

    // Stage 1: product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
        end else if (clr) begin
            r_prod_vld <= 1'b0;
        end else if (!w_stall) begin
            r_prod_vld <= w_accept;
            if (w_accept) begin
                r_prod <= w_mul;
            end
        end
    end

    // Stage 2: accumulator, element counter and sticky overflow.
    // clr wins over stall so an abort is never deferred by a blocked consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (clr) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (w_add) begin
            if (w_last) begin
                r_acc    <= '0;
                r_cnt    <= '0;
                r_sticky <= 1'b0;
            end else begin
                r_acc    <= w_sum;
                r_cnt    <= r_cnt + c_CNT_ONE;
                r_sticky <= r_sticky | w_add_ovf;
            end
        end
    end

    // Output register: a new result may replace a consumed one on the same
    // edge, keeping out_valid high with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (w_load) begin
            out       <= w_sum;
            ovf       <= r_sticky | w_add_ovf;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
